// File: rtl/booth_mul_seq.sv
// Sequential Booth multiplier, signed/unsigned, N-bit operands, 2N-bit product.
// Define BOOTH_RADIX4_EN to select radix-4 modified Booth recoding (two bits per cycle).
module booth_mul_seq #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   data_a,
  input  logic [N-1:0]   data_b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

`ifdef BOOTH_RADIX4_EN
  localparam int W  = ((N + 1) % 2 == 0) ? N + 1 : N + 2;
  localparam int AW = W + 2;
  localparam int SH = 2;
`else
  localparam int W  = N + 1;
  localparam int AW = W;
  localparam int SH = 1;
`endif
  localparam int ITER = W / SH;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   a_q;
  logic [W-1:0]    q_q;
  logic            qm1_q;
  logic [W-1:0]    m_q;
  logic [CW-1:0]   cnt_q;

  logic            accept;
  logic            last_iter;
  logic [W-1:0]    ext_a, ext_b;
  logic [AW-1:0]   m_ext;
  logic [AW-1:0]   a_sum;
  logic [AW+W:0]   shifted;

  assign accept    = start && (state_q != RUN);
  assign last_iter = (state_q == RUN) && (cnt_q == CW'(1));
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

  // The extra bit over N makes unsigned operands positive two's-complement values.
  assign ext_a = signed_mode ? W'($signed(data_a)) : W'(data_a);
  assign ext_b = signed_mode ? W'($signed(data_b)) : W'(data_b);
  assign m_ext = AW'($signed(m_q));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_sum = a_q;
`ifdef BOOTH_RADIX4_EN
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: a_sum = a_q + m_ext;
      3'b011:         a_sum = a_q + (m_ext << 1);
      3'b100:         a_sum = a_q - (m_ext << 1);
      3'b101, 3'b110: a_sum = a_q - m_ext;
      default:        a_sum = a_q;
    endcase
`else
    case ({q_q[0], qm1_q})
      2'b10:   a_sum = a_q - m_ext;
      2'b01:   a_sum = a_q + m_ext;
      default: a_sum = a_q;
    endcase
`endif
    shifted = $signed({a_sum, q_q, qm1_q}) >>> SH;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      product <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= '0;
        q_q   <= ext_b;
        qm1_q <= 1'b0;
        m_q   <= ext_a;
        cnt_q <= CW'(ITER);
      end else if (state_q == RUN) begin
        a_q   <= shifted[AW+W:W+1];
        q_q   <= shifted[W:1];
        qm1_q <= shifted[0];
        cnt_q <= cnt_q - CW'(1);
        // Low 2N bits of {A,Q} after the final shift.
        if (last_iter) product <= shifted[2*N:1];
      end
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq (N=16): vector table plus handshake/reset sequences.
module tb_booth_mul_seq;

`ifdef BOOTH_RADIX4_EN
  localparam int ITER = 9;
`else
  localparam int ITER = 17;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] data_a = '0;
  logic [15:0] data_b = '0;
  logic        busy, done;
  logic [31:0] product;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_prod = '0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  booth_mul_seq #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .data_a(data_a), .data_b(data_b), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] hs_a(input int j);
    return 16'(j * 7 + 3);
  endfunction

  function automatic logic [15:0] hs_b(input int j);
    return 16'(j * 13 + 1);
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sm,
                        input logic [31:0] exp, input string name);
    int   lat;
    bit   seen;
    bit   held_ok;
    @(negedge clk);
    start = 1'b1; data_a = a; data_b = b; signed_mode = sm;
    @(posedge clk); #1;
    start = 1'b0; data_a = ~a; data_b = ~b; signed_mode = ~sm;
    lat = 0; seen = 0; held_ok = 1;
    while (!seen && lat < ITER + 5) begin
      if (!busy || product !== last_prod) held_ok = 0;
      @(posedge clk); lat++; #1;
      seen = done;
    end
    check({name, " latency"}, 64'(lat), 64'(ITER));
    check({name, " product"}, 64'(product), 64'(exp));
    check({name, " busy/held in run"}, 64'(held_ok), 64'd1);
    check({name, " busy low in done"}, 64'(busy), 64'd0);
    last_prod = exp;
  endtask

  initial begin
    int   lat;
    bit   seen;
    int   extra;
    bit   exp_done;

    vecs[0] = '{16'h0005, 16'h0002, 1'b0, 32'h0000000A};
    vecs[1] = '{16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB};
    vecs[2] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vecs[3] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
    vecs[6] = '{16'h1234, 16'h5678, 1'b0, 32'h06260060};
    vecs[7] = '{16'h0000, 16'h1234, 1'b1, 32'h00000000};
    vecs[8] = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000};
    vecs[9] = '{16'h8000, 16'h0002, 1'b0, 32'h00010000};

    // Reset then idle.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", 64'(product), 64'd0);
    rst_n = 1'b1;
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy || done || product !== 32'd0) extra++;
    end
    check("idle outputs stable", 64'(extra), 64'd0);

    // Directed vector table.
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp, $sformatf("vec%0d", i));

    // start held high with fresh operands each cycle: accepts at IDLE and each DONE cycle.
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; data_a = hs_a(0); data_b = hs_b(0);
    for (int j = 0; j <= 3 * ITER + 2; j++) begin
      @(posedge clk); @(negedge clk);
      exp_done = (j >= ITER) && ((j - ITER) % (ITER + 1) == 0);
      check($sformatf("b2b done j=%0d", j), 64'(done), 64'(exp_done));
      if (exp_done)
        check($sformatf("b2b product j=%0d", j), 64'(product),
              64'(32'(hs_a(j - ITER)) * 32'(hs_b(j - ITER))));
      data_a = hs_a(j + 1); data_b = hs_b(j + 1);
    end
    start = 1'b0;
    last_prod = 32'(hs_a(2 * ITER + 2)) * 32'(hs_b(2 * ITER + 2));
    @(posedge clk); #1;
    check("b2b returns idle", 64'(busy), 64'd0);

    // start pulsed mid-RUN is ignored.
    @(negedge clk);
    start = 1'b1; data_a = 16'd3; data_b = 16'd4; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < ITER + 5) begin
      if (lat == 4) begin
        start = 1'b1; data_a = 16'h00FF; data_b = 16'h00FF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); lat++; #1;
      seen = done;
    end
    start = 1'b0;
    check("midrun latency", 64'(lat), 64'(ITER));
    check("midrun product", 64'(product), 64'd12);
    extra = 0;
    repeat (ITER + 3) begin
      @(posedge clk); #1;
      if (busy || done) extra++;
    end
    check("midrun no second op", 64'(extra), 64'd0);
    last_prod = 32'd12;

    // Reset at iteration 6 of 5x2.
    @(negedge clk);
    start = 1'b1; data_a = 16'd5; data_b = 16'd2; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort product", 64'(product), 64'd0);
    extra = 0;
    repeat (ITER + 3) begin
      @(posedge clk); #1;
      if (busy || done) extra++;
    end
    check("abort no done", 64'(extra), 64'd0);
    last_prod = 32'd0;
    run_op(16'd3, 16'd3, 1'b0, 32'd9, "after abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
